cart_mem_bridge: RTL and testbench

- Memory-side counterpart of the cartridge mapper.
- Consumes the mapper's ROM strobe interface (ROM_ADDR/ROM_CE_N/ROM_OE_N/ROM_WORD → ROM_Q) and BSRAM strobe interface (BSRAM_ADDR/D/CE_N/OE_N/WE_N → BSRAM_Q).
- Turns both into word requests on a single SDRAM-controller port using a req/ack handshake.
- Holds returned data stable for the mapper until the next fetch completes.

---
 rtl/cart_mem_bridge.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cart_mem_bridge.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mem_bridge.sv
// cart_mem_bridge: memory-side counterpart of the cartridge mapper.
// It turns the mapper's ROM and BSRAM strobe interfaces into word requests
// on one SDRAM-controller port that uses a req/ack handshake.
// The ROM path and the BSRAM read path each keep a one-word cache, so
// repeated reads of the same word never reach the memory port.
// Read data is held stable for the mapper until the next fetch or cache hit.
module cart_mem_bridge #(
    parameter int                MEM_AW     = 22,
    parameter logic [MEM_AW-1:0] BSRAM_BASE = MEM_AW'(22'h380000)
) (
    input  logic              WCLK,
    input  logic              RST,
    input  logic [23:0]       ROM_ADDR,
    input  logic              ROM_CE_N,
    input  logic              ROM_OE_N,
    input  logic              ROM_WORD,
    output logic [15:0]       ROM_Q,
    input  logic [19:0]       BSRAM_ADDR,
    input  logic [7:0]        BSRAM_D,
    input  logic              BSRAM_CE_N,
    input  logic              BSRAM_OE_N,
    input  logic              BSRAM_WE_N,
    output logic [7:0]        BSRAM_Q,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [MEM_AW-1:0] MEM_ADDR,
    output logic [15:0]       MEM_DIN,
    output logic [1:0]        MEM_BE,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_DOUT,
    output logic              BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_REQ_WR, S_REQ_ROM, S_REQ_RD} state_t;

    state_t            r_state;

    // memory port registers
    logic              r_mem_req;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [15:0]       r_mem_din;
    logic [1:0]        r_mem_be;

    // pending requests and their latched parameters (the latest trigger wins)
    logic              r_rom_pend;
    logic [MEM_AW-1:0] r_rom_wa;
    logic              r_rom_lsb;
    logic              r_rom_wd;
    logic              r_wr_pend;
    logic [19:0]       r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_rd_pend;
    logic [19:0]       r_rd_addr;

    // snapshot of the request in flight, so new triggers cannot disturb it
    logic              r_rom_lsb_q;
    logic              r_rom_wd_q;
    logic [18:0]       r_rd_word_q;
    logic              r_rd_lsb_q;

    // one-word caches
    logic              r_rom_vld;
    logic [MEM_AW-1:0] r_rom_tag;
    logic [15:0]       r_rom_data;
    logic              r_ram_vld;
    logic [18:0]       r_ram_tag;
    logic [15:0]       r_ram_data;

    // output data and edge detection
    logic [15:0]       r_rom_q;
    logic [7:0]        r_bsram_q;
    logic              r_we_n_d;

    logic [MEM_AW-1:0] w_rom_wa;
    logic              w_rom_trig;
    logic              w_rom_hit;
    logic              w_rom_miss;
    logic [18:0]       w_ram_wa;
    logic              w_wr_trig;
    logic              w_rd_trig;
    logic              w_rd_hit;
    logic              w_rd_miss;
    logic              w_rd_kill;
    logic [MEM_AW-1:0] w_wr_maddr;
    logic [MEM_AW-1:0] w_rd_maddr;
    logic              w_unused;

    // ROM byte lane steering: in byte mode [7:0] carries the addressed byte
    function automatic logic [15:0] rom_fmt(input logic [15:0] word,
                                            input logic        lsb,
                                            input logic        wd);
        if (!wd && lsb)
            return {word[7:0], word[15:8]};
        return word;
    endfunction

    // Address bits above the memory port width are dropped by design.
    assign w_unused   = &{1'b0, ROM_ADDR[23:MEM_AW+1]};

    assign w_rom_wa   = ROM_ADDR[MEM_AW:1];
    assign w_rom_trig = !ROM_CE_N && !ROM_OE_N;
    assign w_rom_hit  = w_rom_trig && r_rom_vld && (r_rom_tag == w_rom_wa);
    assign w_rom_miss = w_rom_trig && !w_rom_hit;

    assign w_ram_wa   = BSRAM_ADDR[19:1];
    assign w_wr_trig  = !BSRAM_CE_N && r_we_n_d && !BSRAM_WE_N;
    assign w_rd_trig  = !BSRAM_CE_N && !BSRAM_OE_N;
    // A write to the word in this same cycle makes the cached copy stale.
    assign w_rd_hit   = w_rd_trig && !w_wr_trig && r_ram_vld && (r_ram_tag == w_ram_wa);
    assign w_rd_miss  = w_rd_trig && !w_rd_hit;

    // A read that returns while a write to the same word is queued carries
    // old data, so it must not be marked valid in the cache.
    assign w_rd_kill  = (r_wr_pend && (r_wr_addr[19:1] == r_rd_word_q)) ||
                        (w_wr_trig && (w_ram_wa == r_rd_word_q));

    // BSRAM sits at a fixed word offset; the sum wraps at the port width.
    assign w_wr_maddr = BSRAM_BASE + MEM_AW'(r_wr_addr[19:1]);
    assign w_rd_maddr = BSRAM_BASE + MEM_AW'(r_rd_addr[19:1]);

    // Previous BSRAM_WE_N, used to turn a write strobe into a single trigger
    always_ff @(posedge WCLK or posedge RST) begin
        if (RST)
            r_we_n_d <= 1'b1;
        else
            r_we_n_d <= BSRAM_WE_N;
    end

    // Trigger capture, request FSM and cache fill
    always_ff @(posedge WCLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_be    <= 2'b00;
            r_rom_pend  <= 1'b0;
            r_rom_wa    <= '0;
            r_rom_lsb   <= 1'b0;
            r_rom_wd    <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_addr   <= '0;
            r_rom_lsb_q <= 1'b0;
            r_rom_wd_q  <= 1'b0;
            r_rd_word_q <= '0;
            r_rd_lsb_q  <= 1'b0;
            r_rom_vld   <= 1'b0;
            r_rom_tag   <= '0;
            r_rom_data  <= '0;
            r_ram_vld   <= 1'b0;
            r_ram_tag   <= '0;
            r_ram_data  <= '0;
        end else begin
            if (w_rom_miss) begin
                r_rom_pend <= 1'b1;
                r_rom_wa   <= w_rom_wa;
                r_rom_lsb  <= ROM_ADDR[0];
                r_rom_wd   <= ROM_WORD;
            end
            if (w_wr_trig) begin
                r_wr_pend <= 1'b1;
                r_wr_addr <= BSRAM_ADDR;
                r_wr_data <= BSRAM_D;
                if (r_ram_tag == w_ram_wa)
                    r_ram_vld <= 1'b0;
            end
            if (w_rd_miss) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= BSRAM_ADDR;
            end

            case (r_state)
                S_IDLE: begin
                    // A trigger in the issuing cycle re-arms its pend flag.
                    if (r_wr_pend) begin
                        r_wr_pend  <= w_wr_trig;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_wr_maddr;
                        r_mem_din  <= {2{r_wr_data}};
                        r_mem_be   <= r_wr_addr[0] ? 2'b10 : 2'b01;
                        r_state    <= S_REQ_WR;
                    end else if (r_rom_pend) begin
                        r_rom_pend  <= w_rom_miss;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= r_rom_wa;
                        r_mem_be    <= 2'b11;
                        r_rom_lsb_q <= r_rom_lsb;
                        r_rom_wd_q  <= r_rom_wd;
                        r_state     <= S_REQ_ROM;
                    end else if (r_rd_pend) begin
                        r_rd_pend   <= w_rd_miss;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= w_rd_maddr;
                        r_mem_be    <= 2'b11;
                        r_rd_word_q <= r_rd_addr[19:1];
                        r_rd_lsb_q  <= r_rd_addr[0];
                        r_state     <= S_REQ_RD;
                    end
                end
                S_REQ_WR: begin
                    if (MEM_ACK) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_REQ_ROM: begin
                    if (MEM_ACK) begin
                        r_mem_req  <= 1'b0;
                        r_rom_data <= MEM_DOUT;
                        r_rom_tag  <= r_mem_addr;
                        r_rom_vld  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_REQ_RD: begin
                    if (MEM_ACK) begin
                        r_mem_req  <= 1'b0;
                        r_ram_data <= MEM_DOUT;
                        r_ram_tag  <= r_rd_word_q;
                        r_ram_vld  <= !w_rd_kill;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read data registers: a cache hit serves the mapper's current request
    // first; otherwise returning fetch data is steered with the select
    // captured when that fetch was issued.
    always_ff @(posedge WCLK or posedge RST) begin
        if (RST) begin
            r_rom_q   <= 16'h0000;
            r_bsram_q <= 8'hFF;
        end else begin
            if (w_rom_hit)
                r_rom_q <= rom_fmt(r_rom_data, ROM_ADDR[0], ROM_WORD);
            else if (r_state == S_REQ_ROM && MEM_ACK)
                r_rom_q <= rom_fmt(MEM_DOUT, r_rom_lsb_q, r_rom_wd_q);

            if (w_rd_hit)
                r_bsram_q <= BSRAM_ADDR[0] ? r_ram_data[15:8] : r_ram_data[7:0];
            else if (r_state == S_REQ_RD && MEM_ACK)
                r_bsram_q <= r_rd_lsb_q ? MEM_DOUT[15:8] : MEM_DOUT[7:0];
        end
    end

    assign ROM_Q    = r_rom_q;
    assign BSRAM_Q  = r_bsram_q;
    assign MEM_REQ  = r_mem_req;
    assign MEM_WE   = r_mem_we;
    assign MEM_ADDR = r_mem_addr;
    assign MEM_DIN  = r_mem_din;
    assign MEM_BE   = r_mem_be;
    assign BUSY     = (r_state != S_IDLE) | r_rom_pend | r_wr_pend | r_rd_pend;

endmodule

// File: tb/tb_cart_mem_bridge.sv
// Directed bench for cart_mem_bridge: ROM miss/hit, BSRAM write then read,
// simultaneous triggers, a stalled request with superseding triggers, and
// an asynchronous reset in the middle of a request.
module tb_cart_mem_bridge;

    logic        WCLK = 1'b0;
    logic        RST;
    logic [23:0] ROM_ADDR;
    logic        ROM_CE_N, ROM_OE_N, ROM_WORD;
    logic [15:0] ROM_Q;
    logic [19:0] BSRAM_ADDR;
    logic [7:0]  BSRAM_D;
    logic        BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N;
    logic [7:0]  BSRAM_Q;
    logic        MEM_REQ, MEM_WE;
    logic [21:0] MEM_ADDR;
    logic [15:0] MEM_DIN;
    logic [1:0]  MEM_BE;
    logic        MEM_ACK;
    logic [15:0] MEM_DOUT;
    logic        BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    cart_mem_bridge dut (
        .WCLK(WCLK), .RST(RST),
        .ROM_ADDR(ROM_ADDR), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N),
        .ROM_WORD(ROM_WORD), .ROM_Q(ROM_Q),
        .BSRAM_ADDR(BSRAM_ADDR), .BSRAM_D(BSRAM_D), .BSRAM_CE_N(BSRAM_CE_N),
        .BSRAM_OE_N(BSRAM_OE_N), .BSRAM_WE_N(BSRAM_WE_N), .BSRAM_Q(BSRAM_Q),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_DIN(MEM_DIN), .MEM_BE(MEM_BE), .MEM_ACK(MEM_ACK),
        .MEM_DOUT(MEM_DOUT), .BUSY(BUSY)
    );

    always #5 WCLK = ~WCLK;

    task automatic tick();
        @(posedge WCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one-cycle memory acknowledge carrying data
    task automatic ack(input logic [15:0] d);
        MEM_ACK  = 1'b1;
        MEM_DOUT = d;
        tick();
        MEM_ACK  = 1'b0;
        MEM_DOUT = 16'h0000;
    endtask

    // one-cycle ROM read strobe
    task automatic rom_strobe(input logic [23:0] a, input logic wd);
        ROM_ADDR = a;
        ROM_WORD = wd;
        ROM_CE_N = 1'b0;
        ROM_OE_N = 1'b0;
        tick();
        ROM_OE_N = 1'b1;
    endtask

    initial begin
        RST = 1'b1;
        ROM_ADDR = '0; ROM_CE_N = 1'b1; ROM_OE_N = 1'b1; ROM_WORD = 1'b0;
        BSRAM_ADDR = '0; BSRAM_D = '0; BSRAM_CE_N = 1'b1; BSRAM_OE_N = 1'b1;
        BSRAM_WE_N = 1'b1; MEM_ACK = 1'b0; MEM_DOUT = '0;
        tick(); tick();
        RST = 1'b0;
        tick();

        // reset state
        chk("rst_rom_q",   32'(ROM_Q),    32'h0000);
        chk("rst_bsram_q", 32'(BSRAM_Q),  32'hFF);
        chk("rst_req",     32'(MEM_REQ),  32'h0);
        chk("rst_we",      32'(MEM_WE),   32'h0);
        chk("rst_addr",    32'(MEM_ADDR), 32'h0);
        chk("rst_din",     32'(MEM_DIN),  32'h0);
        chk("rst_be",      32'(MEM_BE),   32'h0);
        chk("rst_busy",    32'(BUSY),     32'h0);

        // ROM miss, byte mode, odd byte
        rom_strobe(24'h012345, 1'b0);
        chk("miss_req_t1", 32'(MEM_REQ), 32'h0);
        chk("miss_busy",   32'(BUSY),    32'h1);
        tick();
        chk("miss_req_t2", 32'(MEM_REQ),  32'h1);
        chk("miss_we",     32'(MEM_WE),   32'h0);
        chk("miss_addr",   32'(MEM_ADDR), 32'h0091A2);
        tick();
        chk("miss_hold",   32'(MEM_REQ),  32'h1);
        ack(16'hBEEF);
        chk("miss_req_dn", 32'(MEM_REQ), 32'h0);
        chk("miss_rom_q",  32'(ROM_Q),   32'hEFBE);
        chk("miss_idle",   32'(BUSY),    32'h0);

        // ROM hit, even byte and word mode
        rom_strobe(24'h012344, 1'b0);
        chk("hit_rom_q",   32'(ROM_Q),   32'hBEEF);
        chk("hit_busy",    32'(BUSY),    32'h0);
        tick();
        chk("hit_noreq",   32'(MEM_REQ), 32'h0);
        rom_strobe(24'h012345, 1'b1);
        chk("hit_word_q",  32'(ROM_Q),   32'hBEEF);
        tick();
        chk("hit_noreq2",  32'(MEM_REQ), 32'h0);
        ROM_CE_N = 1'b1;

        // BSRAM write at odd byte 3
        BSRAM_ADDR = 20'h00003; BSRAM_D = 8'h5A; BSRAM_CE_N = 1'b0; BSRAM_WE_N = 1'b0;
        tick();
        BSRAM_WE_N = 1'b1;
        chk("wr_busy",  32'(BUSY), 32'h1);
        tick();
        chk("wr_req",   32'(MEM_REQ),  32'h1);
        chk("wr_we",    32'(MEM_WE),   32'h1);
        chk("wr_addr",  32'(MEM_ADDR), 32'h380001);
        chk("wr_be",    32'(MEM_BE),   32'h2);
        chk("wr_din",   32'(MEM_DIN),  32'h5A5A);
        ack(16'h0000);
        chk("wr_done",  32'(MEM_REQ), 32'h0);

        // BSRAM read of the same byte must go to memory
        BSRAM_OE_N = 1'b0;
        tick();
        BSRAM_OE_N = 1'b1;
        tick();
        chk("rd_req",   32'(MEM_REQ),  32'h1);
        chk("rd_we",    32'(MEM_WE),   32'h0);
        chk("rd_addr",  32'(MEM_ADDR), 32'h380001);
        ack(16'h5A77);
        chk("rd_q",     32'(BSRAM_Q), 32'h5A);
        chk("rd_idle",  32'(BUSY),    32'h0);

        // BSRAM read of the other byte of the cached word: hit
        BSRAM_ADDR = 20'h00002; BSRAM_OE_N = 1'b0;
        tick();
        BSRAM_OE_N = 1'b1;
        chk("rdhit_q",  32'(BSRAM_Q), 32'h77);
        tick();
        chk("rdhit_noreq", 32'(MEM_REQ), 32'h0);
        BSRAM_CE_N = 1'b1;

        // simultaneous ROM miss and BSRAM write: write goes first
        ROM_ADDR = 24'h000100; ROM_WORD = 1'b1; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
        BSRAM_ADDR = 20'h00004; BSRAM_D = 8'hC3; BSRAM_CE_N = 1'b0; BSRAM_WE_N = 1'b0;
        tick();
        ROM_OE_N = 1'b1; BSRAM_WE_N = 1'b1; BSRAM_CE_N = 1'b1;
        tick();
        chk("sim_wr_req",  32'(MEM_REQ),  32'h1);
        chk("sim_wr_we",   32'(MEM_WE),   32'h1);
        chk("sim_wr_addr", 32'(MEM_ADDR), 32'h380002);
        chk("sim_wr_be",   32'(MEM_BE),   32'h1);
        chk("sim_wr_din",  32'(MEM_DIN),  32'hC3C3);
        ack(16'h0000);
        chk("sim_gap",     32'(MEM_REQ),  32'h0);
        chk("sim_busy1",   32'(BUSY),     32'h1);
        tick();
        chk("sim_rom_req", 32'(MEM_REQ),  32'h1);
        chk("sim_rom_we",  32'(MEM_WE),   32'h0);
        chk("sim_rom_addr",32'(MEM_ADDR), 32'h000080);
        ack(16'h1234);
        chk("sim_rom_q",   32'(ROM_Q),    32'h1234);
        chk("sim_busy0",   32'(BUSY),     32'h0);

        // stalled ROM request, two newer triggers while waiting
        rom_strobe(24'h000200, 1'b0);
        tick();
        chk("stl_req",   32'(MEM_REQ),  32'h1);
        chk("stl_addr",  32'(MEM_ADDR), 32'h000100);
        tick();
        rom_strobe(24'h000401, 1'b0);
        tick();
        rom_strobe(24'h000601, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        chk("stl_hold_addr", 32'(MEM_ADDR), 32'h000100);
        chk("stl_hold_req",  32'(MEM_REQ),  32'h1);
        ack(16'hAA55);
        chk("stl_q1",    32'(ROM_Q),   32'hAA55);
        chk("stl_gap",   32'(MEM_REQ), 32'h0);
        tick();
        chk("stl_req2",  32'(MEM_REQ),  32'h1);
        chk("stl_addr2", 32'(MEM_ADDR), 32'h000300);
        ack(16'h1357);
        chk("stl_q2",    32'(ROM_Q),   32'h5713);
        chk("stl_busy",  32'(BUSY),    32'h0);
        tick(); tick(); tick();
        chk("stl_noreq3", 32'(MEM_REQ), 32'h0);

        // asynchronous reset while a request is outstanding
        rom_strobe(24'h000800, 1'b1);
        tick();
        chk("ar_req", 32'(MEM_REQ), 32'h1);
        #2 RST = 1'b1;
        #1;
        chk("ar_req_dn",  32'(MEM_REQ),  32'h0);
        chk("ar_rom_q",   32'(ROM_Q),    32'h0000);
        chk("ar_bsram_q", 32'(BSRAM_Q),  32'hFF);
        chk("ar_addr",    32'(MEM_ADDR), 32'h0);
        chk("ar_busy",    32'(BUSY),     32'h0);
        #1 RST = 1'b0;
        ROM_CE_N = 1'b1;
        tick();
        ack(16'hFFFF);
        chk("ar_stray_rom_q",   32'(ROM_Q),   32'h0000);
        chk("ar_stray_bsram_q", 32'(BSRAM_Q), 32'hFF);
        chk("ar_stray_req",     32'(MEM_REQ), 32'h0);
        tick();
        chk("ar_stray_busy",    32'(BUSY),    32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
